// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared types and constants for the multiplexed display
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  localparam logic [3:0]  BCD_APAGADO = 4'b1111;
  localparam logic [13:0] VALOR_MAX   = 14'd9999;
  localparam int          N_ITER      = 14;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] ajusta_bcd(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conversor_bin_bcd.sv
// ============================================================================
// conversor_bin_bcd : sequential double-dabble, one iteration per clock
// Revision          : 1.0
// ============================================================================
`default_nettype none

module conversor_bin_bcd
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [13:0] bin,
  output logic        ocupado,
  output logic        pronto,
  output logic [15:0] bcd
);

  estado_t     estado_q, estado_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        ocupado_q, ocupado_d;
  logic        pronto_q, pronto_d;
  logic [29:0] desloc;

  always_comb begin
    estado_d  = estado_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    ocupado_d = ocupado_q;
    pronto_d  = pronto_q;
    desloc    = {ajusta_bcd(bcd_q), bin_q} << 1;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          bin_d     = bin;
          bcd_d     = 16'h0000;
          iter_d    = 4'd0;
          ocupado_d = 1'b1;
          estado_d  = CONVERTE;
        end
      end
      CONVERTE: begin
        {bcd_d, bin_d} = desloc;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'(N_ITER - 1)) begin
          pronto_d = 1'b1;
          estado_d = ATUALIZA;
        end
      end
      ATUALIZA: begin
        pronto_d  = 1'b0;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: begin
        pronto_d  = 1'b0;
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      bin_q     <= 14'd0;
      bcd_q     <= 16'h0000;
      iter_q    <= 4'd0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign bcd     = bcd_q;

endmodule

`default_nettype wire

// File: rtl/varredura_display.sv
// ============================================================================
// varredura_display : binary-to-BCD load plus four-digit multiplexed scanner
// Revision          : 1.0
// ============================================================================
`default_nettype none

module varredura_display
  import display_pkg::*;
#(
  parameter int DIV_VARREDURA = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] valor,
  input  logic        carregar,
  input  logic        apagar_zeros,
  output logic        ocupado,
  output logic [3:0]  digito,
  output logic [3:0]  anodos
);

  localparam int            DW      = $clog2(DIV_VARREDURA);
  localparam logic [DW-1:0] DIV_FIM = DW'(DIV_VARREDURA - 1);

  logic [13:0]   valor_sat;
  logic          pronto;
  logic [15:0]   bcd;

  logic [15:0]   exibe_q, exibe_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digito_q, digito_d;
  logic [3:0]    anodos_q, anodos_d;
  logic [3:0]    apaga;
  logic [3:0]    nibble;

  assign valor_sat = (valor > VALOR_MAX) ? VALOR_MAX : valor;

  conversor_bin_bcd u_conversor (
    .clk     (clk),
    .rst     (rst),
    .inicio  (carregar),
    .bin     (valor_sat),
    .ocupado (ocupado),
    .pronto  (pronto),
    .bcd     (bcd)
  );

  always_comb begin
    exibe_d = pronto ? bcd : exibe_q;

    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DIV_FIM) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Leading-zero blanking cascades down from thousands; units never blank.
    apaga[3] = apagar_zeros && (exibe_q[15:12] == 4'd0);
    apaga[2] = apaga[3] && (exibe_q[11:8] == 4'd0);
    apaga[1] = apaga[2] && (exibe_q[7:4] == 4'd0);
    apaga[0] = 1'b0;

    case (idx_d)
      2'd0:    nibble = exibe_q[3:0];
      2'd1:    nibble = exibe_q[7:4];
      2'd2:    nibble = exibe_q[11:8];
      default: nibble = exibe_q[15:12];
    endcase

    // Digit and anode are both derived from the next index so they switch together.
    digito_d = apaga[idx_d] ? BCD_APAGADO : nibble;
    anodos_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exibe_q  <= 16'h0000;
      div_q    <= '0;
      idx_q    <= 2'd0;
      digito_q <= 4'b0000;
      anodos_q <= 4'b1110;
    end else begin
      exibe_q  <= exibe_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      digito_q <= digito_d;
      anodos_q <= anodos_d;
    end
  end

  assign digito = digito_q;
  assign anodos = anodos_q;

endmodule

`default_nettype wire

// File: tb/tb_varredura_display.sv
// ============================================================================
// tb_varredura_display : vector table, random loads and scan/reset sequences
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_varredura_display;

  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic [13:0] valor;
  logic        carregar;
  logic        apagar_zeros;
  logic        ocupado;
  logic [3:0]  digito;
  logic [3:0]  anodos;

  int          checks;
  int          errors;
  int          edges;
  logic [15:0] exibe_m;

  typedef struct {
    int          valor;
    bit          apagar;
    logic [15:0] exibe;
  } vec_t;

  vec_t tab[11];

  varredura_display #(.DIV_VARREDURA(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .valor        (valor),
    .carregar     (carregar),
    .apagar_zeros (apagar_zeros),
    .ocupado      (ocupado),
    .digito       (digito),
    .anodos       (anodos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release; scan position follows from it.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at t=%0t", nome, got, exp, $time);
    end
  endtask

  function automatic int pot10(input int p);
    int r;
    r = 1;
    for (int k = 0; k < p; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] dig_esp(input int v, input bit ap, input int pos);
    int s;
    s = (v > 9999) ? 9999 : v;
    if (ap && pos > 0 && s < pot10(pos)) return 4'b1111;
    return 4'((s / pot10(pos)) % 10);
  endfunction

  function automatic logic [15:0] bcd_esp(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check_scan(input int v, input bit ap);
    int idx;
    for (int c = 0; c < 4 * DIV; c++) begin
      @(negedge clk);
      idx = (edges / DIV) % 4;
      chk("anodos", {28'd0, anodos}, {28'd0, ~(4'b0001 << idx)});
      chk("digito", {28'd0, digito}, {28'd0, dig_esp(v, ap, idx)});
    end
  endtask

  // Called at a negedge; intr >= 0 injects a stray 5678 load seen at edge N+intr+1.
  task automatic carrega(input int v, input logic [15:0] exp_ex, input int intr);
    logic [15:0] velho;
    velho    = exibe_m;
    valor    = 14'(v);
    carregar = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      carregar = (i == intr);
      if (i == intr) valor = 14'd5678;
      if (i <= 15) chk("ocupado", {31'd0, ocupado}, {31'd0, (i < 15)});
      if (i == 14) chk("exibe_antes", {16'd0, dut.exibe_q}, {16'd0, velho});
      if (i == 15) chk("exibe_nova", {16'd0, dut.exibe_q}, {16'd0, exp_ex});
      if (i == 16) chk("ocupado_apos", {31'd0, ocupado}, 32'd0);
    end
    exibe_m = exp_ex;
  endtask

  initial begin
    int          v;
    bit          ap;

    checks       = 0;
    errors       = 0;
    exibe_m      = 16'h0000;
    rst          = 1'b0;
    valor        = 14'd0;
    carregar     = 1'b0;
    apagar_zeros = 1'b0;

    tab[0]  = '{1234,  1'b0, 16'h1234};
    tab[1]  = '{12000, 1'b0, 16'h9999};
    tab[2]  = '{7,     1'b1, 16'h0007};
    tab[3]  = '{7,     1'b0, 16'h0007};
    tab[4]  = '{0,     1'b1, 16'h0000};
    tab[5]  = '{9999,  1'b1, 16'h9999};
    tab[6]  = '{10000, 1'b0, 16'h9999};
    tab[7]  = '{16383, 1'b1, 16'h9999};
    tab[8]  = '{1005,  1'b1, 16'h1005};
    tab[9]  = '{50,    1'b1, 16'h0050};
    tab[10] = '{100,   1'b1, 16'h0100};

    #2 rst = 1'b1;
    #1;
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_digito",  {28'd0, digito},  32'd0);
    chk("rst_anodos",  {28'd0, anodos},  32'h0000000e);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rel_anodos", {28'd0, anodos}, 32'h0000000e);
    check_scan(0, 1'b0);

    for (int t = 0; t < 11; t++) begin
      apagar_zeros = tab[t].apagar;
      carrega(tab[t].valor, tab[t].exibe, -1);
      check_scan(tab[t].valor, tab[t].apagar);
    end

    // Live blanking toggle on a held value.
    apagar_zeros = 1'b0;
    @(negedge clk);
    check_scan(100, 1'b0);

    // Stray load in CONVERTE and in ATUALIZA must both be dropped.
    carrega(1234, 16'h1234, 4);
    check_scan(1234, 1'b0);
    carrega(4444, 16'h4444, 14);
    check_scan(4444, 1'b0);

    for (int r = 0; r < 14; r++) begin
      v = $urandom_range(0, 16383);
      if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 120);
      ap = 1'($urandom_range(0, 1));
      apagar_zeros = ap;
      carrega(v, bcd_esp(v), -1);
      check_scan(v, ap);
    end

    // Reset in the middle of a conversion.
    valor    = 14'd4321;
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("mid_rst_exibe",   {16'd0, dut.exibe_q}, 32'd0);
    chk("mid_rst_anodos",  {28'd0, anodos}, 32'h0000000e);
    chk("mid_rst_digito",  {28'd0, digito}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exibe_m = 16'h0000;
    repeat (20) @(negedge clk);
    chk("pos_rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("pos_rst_exibe",   {16'd0, dut.exibe_q}, 32'd0);
    check_scan(0, apagar_zeros);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/varredura_display.md
# varredura_display

Four-digit multiplexed display front end that sits directly upstream of the BCD-to-seven-segment decoder. It accepts a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto one shared 4-bit digit bus, which feeds the decoder input, while driving the active-low digit anodes. Code 4'b1111 on the digit bus means "blank": the downstream decoder maps it to all segments off.

## Interface
- DIV_VARREDURA, 50000: clock cycles each digit stays lit; legal range ≥ 2.
- clk  in  1  system clock; every register samples on the rising edge.
- rst  in  1  reset, asynchronous and active-high; the block has one clock.
- valor  in  14  binary value to display; values > 9999 saturate to 9999.
- carregar  in  1  single-cycle load strobe; sampled only while ocupado = 0.
- apagar_zeros  in  1  1 = blank leading zeros; the units digit is always shown. Sampled live.
- ocupado  out  1  high while a conversion is in progress.
- digito  out  4  BCD digit, or 4'b1111 for blank; goes to the decoder input.
- anodos  out  4  active-low one-hot digit enable; bit 0 = units, bit 3 = thousands.

## Operation
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- OCIOSO:
  - carregar = 1 captures min(valor, 9999).
  - Clears the 16-bit BCD shift register and the iteration counter.
  - Moves to CONVERTE.
- CONVERTE:
  - 14 iterations, one per clock.
  - Each iteration: add 3 to any BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - After the 14th iteration, moves to ATUALIZA.
- ATUALIZA: copies the BCD result into the display register `exibe[15:0]`, then returns to OCIOSO.
- carregar while ocupado = 1 is ignored. Nothing is queued.
- The display register changes only in ATUALIZA. The scanner never shows a partially converted value.
- Scanner: free-running, independent of the FSM.
  - Divider counts 0 … DIV_VARREDURA−1.
  - At terminal count the divider resets and the digit index (2 bits) increments, wrapping 3 → 0.
- Digit select:
  - anodos = ~(1 << index).
  - digito = exibe nibble[index], or 4'b1111 when that position is blanked.
- Blanking, when apagar_zeros = 1:
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
- Reset (asynchronous, any state, including mid-conversion):
  - FSM goes to OCIOSO and the conversion in progress is discarded.
  - ocupado = 0, exibe = 16'h0000, divider = 0, index = 0.
  - digito = 4'b0000, anodos = 4'b1110.

## Timing
- All outputs are registered.
- Conversion latency: carregar high at edge N.
  - ocupado is high from after edge N through edge N+15.
  - exibe is updated at edge N+15.
  - ocupado falls after edge N+15.
  - A new carregar is accepted at edge N+16 at the earliest.
- digito and anodos change on the same edge. There is no cycle in which an anode is enabled with a stale digit.
- Each digit is lit for exactly DIV_VARREDURA cycles. A full scan takes 4·DIV_VARREDURA cycles.
- Blanking follows apagar_zeros and exibe with one cycle of latency, because digito is registered.
- When carregar coincides with scanner terminal count, both take effect on the same edge and neither disturbs the other.

## Structure
- Shared package `display_pkg`:
  - FSM state enum (OCIOSO, CONVERTE, ATUALIZA).
  - BCD_APAGADO = 4'b1111.
  - VALOR_MAX = 14'd9999.
  - N_ITER = 14.
- Sub-module `conversor_bin_bcd` holds the sequential double-dabble engine.
  - Ports: clk, rst, inicio, bin[13:0], ocupado, pronto, bcd[15:0].
  - The top level contains only saturation, the display register, the scanner and blanking.

## Test plan
- Reset with DIV_VARREDURA = 4, then hold → anodos = 1110 and digito = 0 first; afterwards anodos cycles 1101, 1011, 0111 with digito = 0, each for 4 clocks.
- valor = 1234 with a one-cycle carregar → ocupado high for 15 cycles, exibe = 16'h1234 at N+15; the scan shows digits 4, 3, 2, 1 on anodos bits 0–3.
- valor = 12000 → exibe = 16'h9999 (saturation).
- valor = 7, apagar_zeros = 1 → digito = 1111, 1111, 1111 on thousands, hundreds and tens, and 0111 on units; with apagar_zeros = 0 → 0, 0, 0, 7. valor = 0 with blanking → only the units digit shows 0.
- Load 1234, then pulse carregar with valor = 5678 at N+5 → the second load is ignored and exibe = 16'h1234.
- Load 4321, then assert rst at N+7 → ocupado = 0 immediately, exibe = 0, and no later update to 16'h4321 occurs.
